// File: rtl/mem_access_arbiter_pkg.sv
// Shared owner encodings, latency constants and stage-register layout for the
// instruction-fetch / load-store memory arbiter.
package mem_access_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    localparam int MEM_RD_LAT   = 1;
    localparam int ARB_RESP_LAT = 2;
    localparam int WAIT_CNT_W   = 4;

endpackage

// File: rtl/mem_access_arbiter_resp_stage.sv
// Second pipeline stage: aligns returning RAM data with its owner, registers
// per-requester read data and emits the one-cycle valid pulses.
module mem_resp_stage
    import mem_access_arbiter_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_p1,
    input  logic [1:0]        own_p1,
    input  logic              rd_p1,
    input  logic [DATA_W-1:0] mem_q,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata
);

    logic       vld_p2;
    logic [1:0] own_p2;

    // ---- stage 1 -> stage 2: mem_q is valid for the access granted last cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            own_p2  <= OWN_NONE;
            f_rdata <= '0;
            d_rdata <= '0;
        end else begin
            vld_p2 <= vld_p1;
            own_p2 <= own_p1;
            // Stores leave d_rdata untouched so it keeps the last loaded word.
            if (vld_p1 && rd_p1 && (own_p1 == OWN_FETCH)) f_rdata <= mem_q;
            if (vld_p1 && rd_p1 && (own_p1 == OWN_DATA))  d_rdata <= mem_q;
        end
    end

    assign f_valid = vld_p2 && (own_p2 == OWN_FETCH);
    assign d_valid = vld_p2 && (own_p2 == OWN_DATA);

endmodule

// File: rtl/mem_access_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store: data has
// priority, fetch is forced through after MAX_WAIT consecutive denials.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  fetch_forced;
    logic                  vld_p1;
    logic [1:0]            own_p1;
    logic                  rd_p1;

    assign fetch_forced = (wait_cnt == WAIT_CNT_W'(MAX_WAIT));

    // ---- stage 0: combinational grant and RAM port mux
    always_comb begin
        f_gnt    = 1'b0;
        d_gnt    = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        if (!rst) begin
            f_gnt = f_req && (!d_req || fetch_forced);
            d_gnt = d_req && !f_gnt;
        end
        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (d_gnt) begin
            mem_addr = d_addr;
            mem_data = d_wdata;
            mem_wren = d_we;
        end
    end

    // Counts consecutive denied fetch cycles; saturates so the force condition holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (f_req && !f_gnt) begin
            if (!fetch_forced) wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // ---- stage 0 -> stage 1: remember who owns the access now at the RAM
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            own_p1 <= OWN_NONE;
            rd_p1  <= 1'b0;
        end else begin
            vld_p1 <= f_gnt || d_gnt;
            own_p1 <= f_gnt ? OWN_FETCH : (d_gnt ? OWN_DATA : OWN_NONE);
            rd_p1  <= f_gnt || (d_gnt && !d_we);
        end
    end

    mem_resp_stage #(.DATA_W(DATA_W)) u_resp (
        .clk     (clk),
        .rst     (rst),
        .vld_p1  (vld_p1),
        .own_p1  (own_p1),
        .rd_p1   (rd_p1),
        .mem_q   (mem_q),
        .f_valid (f_valid),
        .f_rdata (f_rdata),
        .d_valid (d_valid),
        .d_rdata (d_rdata)
    );

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural 1-cycle sync RAM
// preloaded with mem[i] = 16'h1000 + i.
module tb_mem_access_arbiter;

    logic        clk;
    logic        rst;
    logic        f_req;
    logic [7:0]  f_addr;
    logic        f_gnt;
    logic        f_valid;
    logic [15:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [15:0] d_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic [15:0] mem_q;

    logic [15:0] mem [0:255];
    int tests;
    int fails;

    mem_access_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_WAIT(3)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: write at the edge, read data (post-write order) next cycle.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem_q = '0;
        forever begin
            @(posedge clk);
            if (mem_wren) mem[mem_addr] <= mem_data;
            mem_q <= mem[mem_addr];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; f_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        f_addr = 8'h01; d_addr = 8'h02; d_wdata = 16'hAAAA;
        cyc(); cyc(); #1;
        tests++; if (f_gnt !== 1'b0) begin fails++; $display("FAIL reset_f_gnt: got %b want 0", f_gnt); end
        tests++; if (d_gnt !== 1'b0) begin fails++; $display("FAIL reset_d_gnt: got %b want 0", d_gnt); end
        tests++; if (mem_wren !== 1'b0) begin fails++; $display("FAIL reset_mem_wren: got %b want 0", mem_wren); end
        tests++; if (f_valid !== 1'b0 || d_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got f=%b d=%b want 0 0", f_valid, d_valid); end
        tests++; if (f_rdata !== 16'h0 || d_rdata !== 16'h0) begin fails++; $display("FAIL reset_rdata: got f=%h d=%h want 0 0", f_rdata, d_rdata); end
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        cyc(); rst = 1'b0;
        cyc();
    endtask

    task automatic test_single_fetch();
        f_req = 1'b1; f_addr = 8'h05; #1;
        tests++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin fails++; $display("FAIL fetch_gnt: got f=%b d=%b want 1 0", f_gnt, d_gnt); end
        tests++; if (mem_addr !== 8'h05 || mem_wren !== 1'b0) begin fails++; $display("FAIL fetch_mem_addr: got %h wren=%b want 05 0", mem_addr, mem_wren); end
        cyc(); f_req = 1'b0; #1;
        tests++; if (f_valid !== 1'b0) begin fails++; $display("FAIL fetch_early_valid: got %b want 0", f_valid); end
        tests++; if (mem_addr !== 8'h00 || f_gnt !== 1'b0) begin fails++; $display("FAIL fetch_idle: got addr=%h gnt=%b want 00 0", mem_addr, f_gnt); end
        cyc();
        tests++; if (f_valid !== 1'b1 || f_rdata !== 16'h1005) begin fails++; $display("FAIL fetch_resp: got v=%b %h want 1 1005", f_valid, f_rdata); end
        cyc();
        tests++; if (f_valid !== 1'b0 || f_rdata !== 16'h1005) begin fails++; $display("FAIL fetch_hold: got v=%b %h want 0 1005", f_valid, f_rdata); end
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 16'hBEEF; #1;
        tests++; if (d_gnt !== 1'b1 || mem_wren !== 1'b1) begin fails++; $display("FAIL store_gnt: got gnt=%b wren=%b want 1 1", d_gnt, mem_wren); end
        tests++; if (mem_addr !== 8'h20 || mem_data !== 16'hBEEF) begin fails++; $display("FAIL store_bus: got %h/%h want 20/beef", mem_addr, mem_data); end
        cyc(); d_we = 1'b0; #1;
        tests++; if (d_gnt !== 1'b1 || mem_wren !== 1'b0) begin fails++; $display("FAIL load_gnt: got gnt=%b wren=%b want 1 0", d_gnt, mem_wren); end
        cyc(); d_req = 1'b0; #1;
        tests++; if (d_valid !== 1'b1 || d_rdata !== 16'h0000) begin fails++; $display("FAIL store_resp: got v=%b %h want 1 0000", d_valid, d_rdata); end
        tests++; if (mem_wren !== 1'b0) begin fails++; $display("FAIL store_wren_once: got %b want 0", mem_wren); end
        cyc();
        tests++; if (d_valid !== 1'b1 || d_rdata !== 16'hBEEF) begin fails++; $display("FAIL raw_load_resp: got v=%b %h want 1 beef", d_valid, d_rdata); end
        cyc();
        tests++; if (d_valid !== 1'b0) begin fails++; $display("FAIL load_pulse: got %b want 0", d_valid); end
    endtask

    task automatic test_starvation();
        f_req = 1'b1; f_addr = 8'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30; #1;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if ((i % 4) == 3) begin
                if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin fails++; $display("FAIL starve_cycle%0d: got f=%b d=%b want F", i, f_gnt, d_gnt); end
            end else begin
                if (f_gnt !== 1'b0 || d_gnt !== 1'b1) begin fails++; $display("FAIL starve_cycle%0d: got f=%b d=%b want D", i, f_gnt, d_gnt); end
            end
            cyc();
        end
        f_req = 1'b0; d_req = 1'b0;
        cyc(); cyc();
        tests++; if (f_rdata !== 16'h1010 || d_rdata !== 16'h1030) begin fails++; $display("FAIL starve_data: got f=%h d=%h want 1010 1030", f_rdata, d_rdata); end
    endtask

    task automatic test_back_to_back();
        f_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) f_addr = 8'(i); else f_req = 1'b0;
            #1;
            if (i < 8) begin
                tests++; if (f_gnt !== 1'b1) begin fails++; $display("FAIL b2b_gnt%0d: got %b want 1", i, f_gnt); end
            end
            if (i >= 2) begin
                tests++; if (f_valid !== 1'b1 || f_rdata !== 16'h1000 + 16'(i - 2)) begin
                    fails++; $display("FAIL b2b_resp%0d: got v=%b %h want 1 %h", i, f_valid, f_rdata, 16'h1000 + 16'(i - 2));
                end
            end else begin
                tests++; if (f_valid !== 1'b0) begin fails++; $display("FAIL b2b_early%0d: got %b want 0", i, f_valid); end
            end
            cyc();
        end
        tests++; if (f_valid !== 1'b0) begin fails++; $display("FAIL b2b_tail: got %b want 0", f_valid); end
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h40; #1;
        tests++; if (d_gnt !== 1'b1) begin fails++; $display("FAIL rmid_gnt: got %b want 1", d_gnt); end
        cyc(); rst = 1'b1; d_we = 1'b1; d_wdata = 16'h5555; #1;
        tests++; if (d_gnt !== 1'b0 || mem_wren !== 1'b0) begin fails++; $display("FAIL rmid_wren: got gnt=%b wren=%b want 0 0", d_gnt, mem_wren); end
        cyc(); rst = 1'b0; d_req = 1'b0; d_we = 1'b0; #1;
        tests++; if (d_valid !== 1'b0 || d_rdata !== 16'h0) begin fails++; $display("FAIL rmid_flush: got v=%b %h want 0 0000", d_valid, d_rdata); end
        cyc();
        tests++; if (d_valid !== 1'b0 || d_rdata !== 16'h0) begin fails++; $display("FAIL rmid_after: got v=%b %h want 0 0000", d_valid, d_rdata); end
        cyc();
    endtask

    task automatic test_store_then_fetch();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h41;
        cyc(); d_we = 1'b1; d_addr = 8'h50; d_wdata = 16'h1234;
        cyc(); d_req = 1'b0; d_we = 1'b0; f_req = 1'b1; f_addr = 8'h06; #1;
        tests++; if (d_valid !== 1'b1 || d_rdata !== 16'h1041 || f_gnt !== 1'b1) begin fails++; $display("FAIL sf_load: got v=%b %h gnt=%b want 1 1041 1", d_valid, d_rdata, f_gnt); end
        cyc(); f_req = 1'b0; #1;
        tests++; if (d_valid !== 1'b1 || d_rdata !== 16'h1041 || f_valid !== 1'b0) begin fails++; $display("FAIL sf_store: got v=%b %h fv=%b want 1 1041 0", d_valid, d_rdata, f_valid); end
        cyc();
        tests++; if (f_valid !== 1'b1 || f_rdata !== 16'h1006 || d_valid !== 1'b0 || d_rdata !== 16'h1041) begin
            fails++; $display("FAIL sf_fetch: got fv=%b %h dv=%b %h want 1 1006 0 1041", f_valid, f_rdata, d_valid, d_rdata);
        end
        cyc();
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        test_store_then_fetch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
